// File: rtl/cpu_oci_trace_packer.sv
// Packs narrow OCI trace entries into wide frames and hands them to the debug drain.
// On test_ending the partial frame is flushed, then test_has_ended latches until reset.
module cpu_oci_trace_packer #(
   parameter int ENTRY_W = 2,
   parameter int SLOTS   = 15,
   parameter int BUF_W   = ENTRY_W * SLOTS,
   parameter int CNT_W   = $clog2(SLOTS + 1),
   parameter int DROP_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               entry_valid,
   input  logic [ENTRY_W-1:0] entry_data,
   input  logic               test_ending,
   input  logic               out_ready,
   output logic [BUF_W-1:0]   dct_buffer,
   output logic [CNT_W-1:0]   dct_count,
   output logic               frame_valid,
   output logic [BUF_W-1:0]   frame_data,
   output logic [CNT_W-1:0]   frame_count,
   output logic [DROP_W-1:0]  drop_count,
   output logic               test_has_ended,
   output logic [1:0]         fsm_state
);

   // Output handshake: a frame is offered while frame_valid is high and completes on a
   // cycle with frame_valid && out_ready; frame_data/frame_count hold until then.

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] FULL = CNT_W'(SLOTS);

   state_t state;
   state_t state_next;
   logic   slot_free;
   logic   xfer;
   logic   accept;
   logic   drop;

   assign fsm_state = state;

   always_comb begin
      slot_free  = !frame_valid || out_ready;
      xfer       = (state != DONE) &&
                   ((dct_count == FULL) || (state == FLUSH && dct_count != '0)) &&
                   slot_free;
      // A full buffer still accepts when it empties into the output slot this cycle.
      accept     = (state == RUN) && entry_valid && ((dct_count != FULL) || xfer);
      drop       = (state == RUN) && entry_valid && (dct_count == FULL) && !xfer;
      state_next = state;
      case (state)
         RUN:     if (test_ending) state_next = FLUSH;
         FLUSH:   if (dct_count == '0 && !frame_valid) state_next = DONE;
         default: state_next = DONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= RUN;
         dct_buffer     <= '0;
         dct_count      <= '0;
         frame_valid    <= 1'b0;
         frame_data     <= '0;
         frame_count    <= '0;
         drop_count     <= '0;
         test_has_ended <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next == DONE) test_has_ended <= 1'b1;

         if (xfer) begin
            frame_data  <= dct_buffer;
            frame_count <= dct_count;
            frame_valid <= 1'b1;
         end else if (out_ready) begin
            frame_valid <= 1'b0;
         end

         if (xfer) begin
            dct_buffer <= accept ? BUF_W'(entry_data) : '0;
            dct_count  <= accept ? CNT_W'(1) : '0;
         end else if (accept) begin
            dct_buffer <= {dct_buffer[BUF_W-ENTRY_W-1:0], entry_data};
            dct_count  <= dct_count + CNT_W'(1);
         end

         if (drop && drop_count != '1) drop_count <= drop_count + DROP_W'(1);
      end
   end

endmodule

// File: doc/cpu_oci_trace_packer.md
# cpu_oci_trace_packer

Parametrised debug-trace capture block for the Nios II OCI debug path. It packs narrow trace entries into a wide `dct_buffer` frame with a live `dct_count` and hands full frames to the debug transport over a valid/ready handshake. On `test_ending` it flushes any partial frame and then raises a sticky `test_has_ended`. It is the synthesizable, back-pressure-aware successor to the passive OCI test-bench monitor and sits between the CPU trace source and the JTAG/trace-RAM drain.

## Interface

Parameters:
- `ENTRY_W`, default 2: width of one trace entry.
- `SLOTS`, default 15: entries per frame. `BUF_W = ENTRY_W*SLOTS` (default 30).
- `CNT_W`, default `$clog2(SLOTS+1)` (4): width of the count fields.
- `DROP_W`, default 8: width of the drop counter.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `entry_valid` in 1: trace entry present this cycle.
- `entry_data` in `ENTRY_W`: the trace entry.
- `test_ending` in 1: request to flush and finish; a single-cycle pulse is sufficient.
- `out_ready` in 1: the drain accepts the frame.
- `dct_buffer` out `BUF_W`: working buffer. The newest entry is in the LSBs.
- `dct_count` out `CNT_W`: number of entries in `dct_buffer`, 0..`SLOTS`.
- `frame_valid` out 1: `frame_data`/`frame_count` hold a frame.
- `frame_data` out `BUF_W`: emitted frame.
- `frame_count` out `CNT_W`: number of valid entries in the frame, 1..`SLOTS`.
- `drop_count` out `DROP_W`: entries lost to back-pressure. Saturating.
- `test_has_ended` out 1: sticky completion flag.

## Operation

- States: RUN, FLUSH, DONE. The reset state is RUN.
- **Accept (RUN only).**
  - An entry is accepted when `entry_valid` is high and (`dct_count < SLOTS` or a transfer happens in the same cycle).
  - On accept: `dct_buffer <= {dct_buffer[BUF_W-ENTRY_W-1:0], entry_data}` and `dct_count` increments.
  - If a transfer happens in the same cycle, the entry goes into the cleared buffer, so `dct_count` becomes 1 and the buffer equals the zero-extended entry.
- **Transfer.**
  - Condition: (`dct_count == SLOTS`, or state is FLUSH with `dct_count > 0`) and (`!frame_valid` or `out_ready`).
  - Action: `frame_data <= dct_buffer`, `frame_count <= dct_count`, `frame_valid <= 1`. The buffer clears to 0 and the count to 0.
  - Partial frames are right-aligned and their upper bits are zero.
- **Output handshake.**
  - The frame completes on a cycle where `frame_valid && out_ready`. If no transfer happens that cycle, `frame_valid` drops.
  - While `frame_valid` is high and `out_ready` is low, `frame_data` and `frame_count` hold stable.
- **Drop.** In RUN, if `entry_valid` is high, `dct_count == SLOTS` and no transfer happens, the entry is discarded and `drop_count` increments, saturating at `2^DROP_W-1`.
- **Entering FLUSH.** `test_ending` in RUN moves the state to FLUSH at the next edge. An entry presented in that same cycle is still processed under RUN rules.
- **In FLUSH.**
  - `entry_valid` is ignored and is not counted as a drop.
  - Any residual buffer is transferred when the output slot allows.
  - FLUSH moves to DONE when `dct_count == 0` and `frame_valid == 0` (drain complete).
- **In DONE.**
  - `test_has_ended` is 1 and stays 1 until reset.
  - Entries and `test_ending` are ignored.
  - No further frames are produced.
- `test_ending` in FLUSH or DONE has no effect.
- **Reset.** Every output and the state reset to 0/RUN at the next edge, including mid-frame and mid-flush. A pending frame is discarded.

## Timing

- An entry accepted at edge N is visible in `dct_buffer`/`dct_count` after edge N.
- A buffer that fills at edge N, with the output slot free, gives `frame_valid = 1` after edge N+1. Full-frame latency is 1 cycle.
- Sustained throughput is one entry per cycle with no drops while `out_ready` is held at 1. Back-to-back transfers use the transfer-plus-accept rule.
- Flush latency: a residual buffer with the slot free gives `frame_valid` 2 cycles after the `test_ending` edge. `test_has_ended` rises the edge after the last handshake (FLUSH→DONE).
- With an empty buffer and empty slot, `test_has_ended` is 1 two edges after the `test_ending` edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

1. **Full frame.** Defaults, `out_ready=1`; feed 15 entries with `entry_data = i%4`, i=0..14. Expect one frame with `frame_count=15`, `frame_data` LSBs = `2'd2` (entry 14), `frame_data[29:28] = 2'd0`, and `drop_count=0`.
2. **Back-pressure and drop.** Hold `out_ready=0` and feed 35 entries. Expect frame 1 held, buffer full (`dct_count=15`), and `drop_count=5`. Then raise `out_ready`: frame 2 transfers the next cycle and no more drops occur.
3. **Partial flush.** Feed 3 entries (1,2,3), then pulse `test_ending`. Expect `frame_count=3` and `frame_data=30'h1B`. `test_has_ended` rises one cycle after the handshake, and later entries are ignored.
4. **Empty flush.** Pulse `test_ending` right after reset. Expect no frame and `test_has_ended=1` two edges later.
5. **Simultaneous transfer and accept.** With 15 entries held and `out_ready` rising in the same cycle as an entry (value 3), expect the frame emitted, `dct_count=1`, `dct_buffer=30'h3`, and no drop.
6. **Reset mid-flush.** Assert `reset` while in FLUSH with `frame_valid` held high. Expect all outputs 0, state RUN, and normal capture resuming afterwards.
